// File: rtl/sigmoid_pkg.sv
// Shared types for the sigmoid scheduler slice: widths, requester id, tag and response entries.
package sigmoid_pkg;

  localparam int unsigned INPUT_WIDTH  = 8;
  localparam int unsigned OUTPUT_WIDTH = 16;
  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned ID_WIDTH     = $clog2(NUM_REQ);

  typedef logic [ID_WIDTH-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef struct packed {
    req_id_t                 id;
    logic [OUTPUT_WIDTH-1:0] y;
  } rsp_entry_t;

endpackage

// File: rtl/sigmoid_rr_arbiter.sv
// Round-robin grant among requesters starting at rr_ptr.
// SIGMOID_SCHED_PRIO_EN: requester 0 wins outright; 1..NUM_REQ-1 rotate among themselves.
module sigmoid_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
`ifdef SIGMOID_SCHED_PRIO_EN
      if (req[0]) begin
        grant[0] = 1'b1;
        found    = 1'b1;
      end
`endif
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = (32'(rr_ptr) + i) % NUM_REQ;
`ifdef SIGMOID_SCHED_PRIO_EN
        if (!found && idx != 0 && req[idx]) begin
`else
        if (!found && req[idx]) begin
`endif
          grant[idx] = 1'b1;
          grant_idx  = IDW'(idx);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Shares one registered sigmoid datapath among NUM_REQ requesters with tagged, credit-protected responses.
// Optional SIGMOID_SCHED_PRIO_EN gives requester 0 strict priority.
module sigmoid_scheduler #(
  parameter int unsigned NUM_REQ      = sigmoid_pkg::NUM_REQ,
  parameter int unsigned INPUT_WIDTH  = sigmoid_pkg::INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = sigmoid_pkg::OUTPUT_WIDTH,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_x,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [INPUT_WIDTH-1:0]         sig_x,
  input  logic [OUTPUT_WIDTH-1:0]        sig_y,
  output logic                           rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [OUTPUT_WIDTH-1:0]        rsp_y,
  input  logic                           rsp_ready
);

  import sigmoid_pkg::*;

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  req_id_t            rr_ptr;
  req_id_t            grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               rr_adv;
  logic               issue_ok;
  int unsigned        inflight;

  tag_t               tag_q [LATENCY+1];
  rsp_entry_t         fifo_mem [RSP_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      fifo_count;
  logic               push;
  logic               pop;

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i <= LATENCY; i++) inflight += 32'(tag_q[i].valid);
  end

  // reset also masks the grant so req_ready drops as soon as reset rises
  assign issue_ok = !reset && ((32'(fifo_count) + inflight) < RSP_DEPTH);

  sigmoid_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .enable    (issue_ok),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

`ifdef SIGMOID_SCHED_PRIO_EN
  assign rr_adv = accept && (grant_idx != '0);
`else
  assign rr_adv = accept;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      sig_x  <= '0;
    end else if (accept) begin
      sig_x <= req_x[grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
      if (rr_adv) rr_ptr <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: accept, id: grant_idx};
      for (int unsigned i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign push      = tag_q[LATENCY].valid;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rsp_entry_t'{id: tag_q[LATENCY].id, y: sig_y};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (32'(wr_ptr) == RSP_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (32'(rd_ptr) == RSP_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  assign rsp_id = rsp_valid ? fifo_mem[rd_ptr].id : '0;
  assign rsp_y  = rsp_valid ? fifo_mem[rd_ptr].y  : '0;

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// Directed bench for sigmoid_scheduler with a stub datapath y = x * 256 registered once.
module tb_sigmoid_scheduler;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_x;
  logic [N-1:0] req_ready;
  logic [7:0]   sig_x;
  logic [15:0]  sig_y;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [15:0]  rsp_y;
  logic         rsp_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) sig_y <= {sig_x, 8'h00};

  sigmoid_scheduler #(
    .NUM_REQ      (4),
    .INPUT_WIDTH  (8),
    .OUTPUT_WIDTH (16),
    .LATENCY      (1),
    .RSP_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .sig_x     (sig_x),
    .sig_y     (sig_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_ready (rsp_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_x = '0; rsp_ready = 1'b0;
    tick();
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_y !== 16'h0000) begin n_bad++; $display("FAIL reset_rsp_y got %h want 0000", rsp_y); end
    n_cmp++; if (sig_x !== 8'h00) begin n_bad++; $display("FAIL reset_sig_x got %h want 00", sig_x); end
    tick();
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_x[16 +: 8] = 8'sd5; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant got %b want 0100", req_ready); end
    tick(); req_valid = '0; #1;
    n_cmp++; if (sig_x !== 8'h05) begin n_bad++; $display("FAIL single_sig_x got %h want 05", sig_x); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_c2 got %b want 0", rsp_valid); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_c3 got %b want 0", rsp_valid); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_rsp_id got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_y !== 16'd1280) begin n_bad++; $display("FAIL single_rsp_y got %0d want 1280", rsp_y); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_popped got %b want 0", rsp_valid); end
  endtask

  // rr_ptr is 3 here: req 1 wins after wrap, then rr_ptr=2 so req 3 wins next
  task automatic test_bounds();
    rsp_ready = 1'b1;
    req_valid = 4'b0010; req_x[8 +: 8] = 8'h80; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bound_grant_a got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b1000; req_x[24 +: 8] = 8'h7F; #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bound_grant_b got %b want 1000", req_ready); end
    tick(); req_valid = '0; #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bound_early got %b want 0", rsp_valid); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 16'h8000) begin
      n_bad++; $display("FAIL bound_neg got v=%b id=%0d y=%h want v=1 id=1 y=8000", rsp_valid, rsp_id, rsp_y); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 16'h7F00) begin
      n_bad++; $display("FAIL bound_pos got v=%b id=%0d y=%h want v=1 id=3 y=7F00", rsp_valid, rsp_id, rsp_y); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bound_drained got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_id;
    logic [7:0]  exp_x;
    for (int unsigned i = 0; i < N; i++) req_x[i*8 +: 8] = 8'h0A + 8'(i);
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      #1;
      exp_rdy = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_grant c=%0d got %b want %b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== (c >= 3 && c <= 14)) begin n_bad++; $display("FAIL b2b_valid c=%0d got %b", c, rsp_valid); end
      if (c >= 3 && c <= 14) begin
        exp_id = 2'((c - 3) % 4);
        exp_x  = 8'h0A + 8'(exp_id);
        n_cmp++; if (rsp_id !== exp_id || rsp_y !== {exp_x, 8'h00}) begin
          n_bad++; $display("FAIL b2b_rsp c=%0d got id=%0d y=%h want id=%0d y=%h", c, rsp_id, rsp_y, exp_id, {exp_x, 8'h00}); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    logic [7:0] exp_x;
    for (int unsigned i = 0; i < N; i++) req_x[i*8 +: 8] = 8'h20 + 8'(i);
    for (int c = 0; c < 17; c++) begin
      rsp_ready = (c >= 8);
      req_valid = (c <= 12) ? 4'b1111 : 4'b0000;
      #1;
      if (c <= 3)                exp_rdy = 4'b0001 << c;
      else if (c >= 9 && c <= 12) exp_rdy = 4'b0001 << (c - 9);
      else                        exp_rdy = 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_grant c=%0d got %b want %b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== (c >= 3 && c <= 15)) begin n_bad++; $display("FAIL bp_valid c=%0d got %b", c, rsp_valid); end
      if (c >= 3 && c <= 15) begin
        if (c <= 8)       exp_id = 2'd0;
        else if (c <= 11) exp_id = 2'(c - 8);
        else              exp_id = 2'(c - 12);
        exp_x = 8'h20 + 8'(exp_id);
        n_cmp++; if (rsp_id !== exp_id || rsp_y !== {exp_x, 8'h00}) begin
          n_bad++; $display("FAIL bp_rsp c=%0d got id=%0d y=%h want id=%0d y=%h", c, rsp_id, rsp_y, exp_id, {exp_x, 8'h00}); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_rdy [4];
    exp_rdy[0] = 4'b0010; exp_rdy[1] = 4'b0100; exp_rdy[2] = 4'b1000; exp_rdy[3] = 4'b0010;
    for (int unsigned i = 0; i < N; i++) req_x[i*8 +: 8] = 8'h40 + 8'(i);
    rsp_ready = 1'b0; req_valid = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (req_ready !== exp_rdy[c]) begin n_bad++; $display("FAIL rm_grant c=%0d got %b want %b", c, req_ready, exp_rdy[c]); end
      tick();
    end
    #1;
    n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      n_bad++; $display("FAIL rm_full got rdy=%b v=%b id=%0d want rdy=0000 v=1 id=1", req_ready, rsp_valid, rsp_id); end
    reset = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_y !== 16'h0000 || sig_x !== 8'h00) begin
      n_bad++; $display("FAIL rm_async got rdy=%b v=%b id=%0d y=%h x=%h want all zero", req_ready, rsp_valid, rsp_id, rsp_y, sig_x); end
    tick();
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale c=%0d got %b want 0", c, rsp_valid); end
      tick();
    end
    req_valid = 4'b0110; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rm_first_grant got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_new_early got %b want 0", rsp_valid); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 16'h4100) begin
      n_bad++; $display("FAIL rm_new_rsp got v=%b id=%0d y=%h want v=1 id=1 y=4100", rsp_valid, rsp_id, rsp_y); end
    tick(); #1;
  endtask

`ifdef SIGMOID_SCHED_PRIO_EN
  task automatic test_prio();
    rsp_ready = 1'b1; req_valid = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL prio_grant c=%0d got %b want 0001", c, req_ready); end
      tick();
    end
    req_valid = 4'b0010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL prio_release got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    for (int c = 0; c < 5; c++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_bounds();
`ifdef SIGMOID_SCHED_PRIO_EN
    test_prio();
`else
    test_back_to_back();
    test_backpressure();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
